// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin bus arbiter with per-tenure burst limit, BUS_ready watchdog and owner turnaround
module bus_rr_arbiter #(
  parameter int N_MASTERS = 8,
  parameter int OWN_W     = 3,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [N_MASTERS-1:0] DMA,
  input  logic                 BUS_req,
  input  logic                 BUS_ready,
  output logic [N_MASTERS-1:0] grant,
  output logic [OWN_W-1:0]     owner,
  output logic                 bus_busy,
  output logic                 bus_err
);
  localparam int BW = $clog2(MAX_BURST + 2);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, OWN, XFER, RELEASE} state_t;
  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [OWN_W-1:0]     owner_q, owner_d, rr_ptr_q, rr_ptr_d, win;
  logic [BW-1:0]        burst_q, burst_d;
  logic [WW-1:0]        wd_q, wd_d;
  logic                 err_q, err_d, limit;
  // descending scan so the last hit is the first requester at or above rr_ptr
  always_comb begin
    int idx;
    win = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      idx = idx >= N_MASTERS ? idx - N_MASTERS : idx;
      if (DMA[idx[OWN_W-1:0]]) win = idx[OWN_W-1:0];
    end
  end
  assign limit = (MAX_BURST != 0) && (burst_q == BW'(MAX_BURST)) && |(DMA & ~grant_q);
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    wd_d     = wd_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (|DMA) begin
        state_d = OWN;
        owner_d = win;
        grant_d = N_MASTERS'(1) << win;
      end
      OWN: if (BUS_req) begin
        state_d = XFER;
        wd_d    = '0;
      end else if (!DMA[owner_q] || limit) begin
        state_d = RELEASE;
        grant_d = '0;
      end
      XFER: if (BUS_ready) begin
        state_d = OWN;
        burst_d = burst_q >= BW'(MAX_BURST) ? burst_q : burst_q + 1'b1;
      end else if (wd_q == WW'(TIMEOUT - 1)) begin
        state_d = RELEASE;
        grant_d = '0;
        err_d   = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
      RELEASE: begin
        state_d  = IDLE;
        burst_d  = '0;
        rr_ptr_d = owner_q == OWN_W'(N_MASTERS - 1) ? '0 : owner_q + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
    end
  end
  assign grant    = grant_q;
  assign owner    = owner_q;
  assign bus_busy = (state_q == OWN) || (state_q == XFER);
  assign bus_err  = err_q;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed scenarios plus randomized traffic against a timestamp-based reference model
module tb_bus_rr_arbiter;
  localparam int N = 8, TO = 16, MB = 4;
  logic       clk = 1'b0, clr, BUS_req, BUS_ready, bus_busy, bus_err;
  logic [7:0] DMA, grant;
  logic [2:0] owner;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.N_MASTERS(N), .OWN_W(3), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .DMA(DMA), .BUS_req(BUS_req), .BUS_ready(BUS_ready),
    .grant(grant), .owner(owner), .bus_busy(bus_busy), .bus_err(bus_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; DMA = '0; BUS_req = 1'b0; BUS_ready = 1'b0;
    cyc();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; DMA = 8'hFF; BUS_req = 1'b1; BUS_ready = 1'b1;
    cyc(); cyc();
    checks++;
    if (grant !== 8'h00 || bus_err !== 1'b0 || bus_busy !== 1'b0 || owner !== 3'd0) begin
      errors++; $display("FAIL reset_state: grant=%h err=%b busy=%b owner=%0d, want 00 0 0 0", grant, bus_err, bus_busy, owner);
    end
    clr = 1'b0; BUS_req = 1'b0; BUS_ready = 1'b0;
    cyc();
    checks++;
    if (grant !== 8'h01 || bus_busy !== 1'b1) begin
      errors++; $display("FAIL first_grant: grant=%h busy=%b, want 01 1", grant, bus_busy);
    end
    do_reset();
    BUS_req = 1'b1; BUS_ready = 1'b1;
    repeat (3) cyc();
    checks++;
    if (grant !== 8'h00 || bus_busy !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL idle_ignores_bus: grant=%h busy=%b err=%b, want 00 0 0", grant, bus_busy, bus_err);
    end
    BUS_req = 1'b0; BUS_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    DMA = 8'h05;
    cyc();
    checks++;
    if (grant !== 8'h01) begin errors++; $display("FAIL rr_grant0: grant=%h want 01", grant); end
    BUS_req = 1'b1; cyc();
    BUS_req = 1'b0; BUS_ready = 1'b1; DMA = 8'h04; cyc();
    BUS_ready = 1'b0;
    cyc();
    checks++;
    if (grant !== 8'h00 || bus_busy !== 1'b0) begin errors++; $display("FAIL rr_release0: grant=%h busy=%b want 00 0", grant, bus_busy); end
    cyc();
    checks++;
    if (grant !== 8'h00) begin errors++; $display("FAIL rr_idle_gap: grant=%h want 00", grant); end
    cyc();
    checks++;
    if (grant !== 8'h04 || owner !== 3'd2) begin errors++; $display("FAIL rr_grant2: grant=%h owner=%0d want 04 2", grant, owner); end
    BUS_req = 1'b1; cyc();
    BUS_req = 1'b0; BUS_ready = 1'b1; DMA = 8'h01; cyc();
    BUS_ready = 1'b0;
    cyc(); cyc(); cyc();
    checks++;
    if (grant !== 8'h01) begin errors++; $display("FAIL rr_back_to0: grant=%h want 01", grant); end
    DMA = 8'h80; cyc(); cyc(); cyc();
    checks++;
    if (grant !== 8'h80 || owner !== 3'd7) begin errors++; $display("FAIL rr_grant7: grant=%h owner=%0d want 80 7", grant, owner); end
    DMA = 8'h01; cyc();
    DMA = 8'h81; cyc(); cyc();
    checks++;
    if (grant !== 8'h01) begin errors++; $display("FAIL rr_wrap7to0: grant=%h want 01", grant); end
    DMA = 8'h00; cyc(); cyc();
  endtask

  task automatic test_burst_limit();
    logic [7:0] exp;
    do_reset();
    DMA = 8'h03;
    cyc();
    checks++;
    if (grant !== 8'h01) begin errors++; $display("FAIL burst_grant0: grant=%h want 01", grant); end
    for (int k = 1; k <= MB; k++) begin
      BUS_req = 1'b1; cyc();
      BUS_req = 1'b0; BUS_ready = 1'b1; cyc();
      BUS_ready = 1'b0; cyc();
      exp = (k == MB) ? 8'h00 : 8'h01;
      checks++;
      if (grant !== exp) begin errors++; $display("FAIL burst_xfer%0d: grant=%h want %h", k, grant, exp); end
    end
    cyc();
    checks++;
    if (grant !== 8'h00) begin errors++; $display("FAIL burst_gap: grant=%h want 00", grant); end
    cyc();
    checks++;
    if (grant !== 8'h02) begin errors++; $display("FAIL burst_rotate: grant=%h want 02", grant); end
    for (int k = 0; k < 2; k++) begin
      BUS_req = 1'b1; cyc();
      BUS_req = 1'b0; BUS_ready = 1'b1; cyc();
      BUS_ready = 1'b0; cyc();
    end
    do_reset();
    DMA = 8'h01;
    cyc();
    for (int k = 1; k <= 6; k++) begin
      BUS_req = 1'b1; cyc();
      BUS_req = 1'b0; BUS_ready = 1'b1; cyc();
      BUS_ready = 1'b0; cyc();
      checks++;
      if (grant !== 8'h01) begin errors++; $display("FAIL sole_keep%0d: grant=%h want 01", k, grant); end
    end
  endtask

  task automatic test_watchdog();
    int pulses;
    do_reset();
    DMA = 8'h04;
    cyc();
    BUS_req = 1'b1; cyc();
    BUS_req = 1'b0;
    pulses = 0;
    for (int k = 1; k < TO; k++) begin
      cyc();
      if (bus_err === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || grant !== 8'h04) begin errors++; $display("FAIL wd_early: pulses=%0d grant=%h want 0 04", pulses, grant); end
    cyc();
    checks++;
    if (bus_err !== 1'b1 || grant !== 8'h00) begin errors++; $display("FAIL wd_abort: err=%b grant=%h want 1 00", bus_err, grant); end
    DMA = 8'h0C;
    cyc();
    checks++;
    if (bus_err !== 1'b0 || grant !== 8'h00) begin errors++; $display("FAIL wd_after: err=%b grant=%h want 0 00", bus_err, grant); end
    cyc();
    checks++;
    if (grant !== 8'h08) begin errors++; $display("FAIL wd_ptr3: grant=%h want 08", grant); end
  endtask

  task automatic test_ready_at_timeout();
    do_reset();
    DMA = 8'h04;
    cyc();
    BUS_req = 1'b1; cyc();
    BUS_req = 1'b0;
    repeat (TO - 1) cyc();
    BUS_ready = 1'b1;
    cyc();
    BUS_ready = 1'b0;
    checks++;
    if (bus_err !== 1'b0 || grant !== 8'h04 || bus_busy !== 1'b1) begin
      errors++; $display("FAIL ready_at_timeout: err=%b grant=%h busy=%b want 0 04 1", bus_err, grant, bus_busy);
    end
    DMA = 8'h00;
    cyc();
    checks++;
    if (grant !== 8'h00 || bus_err !== 1'b0) begin errors++; $display("FAIL ready_back_own: grant=%h err=%b want 00 0", grant, bus_err); end
  endtask

  task automatic test_mid_transfer();
    do_reset();
    DMA = 8'h02;
    cyc();
    BUS_req = 1'b1; cyc();
    BUS_req = 1'b0; DMA = 8'h00;
    repeat (3) cyc();
    checks++;
    if (grant !== 8'h02) begin errors++; $display("FAIL mid_hold: grant=%h want 02", grant); end
    BUS_ready = 1'b1; cyc();
    BUS_ready = 1'b0;
    checks++;
    if (grant !== 8'h02) begin errors++; $display("FAIL mid_ready: grant=%h want 02", grant); end
    cyc();
    checks++;
    if (grant !== 8'h00) begin errors++; $display("FAIL mid_release: grant=%h want 00", grant); end
    do_reset();
    DMA = 8'h02;
    cyc();
    BUS_req = 1'b1; cyc();
    BUS_req = 1'b0; clr = 1'b1;
    cyc();
    clr = 1'b0; DMA = 8'h00;
    checks++;
    if (grant !== 8'h00 || bus_err !== 1'b0 || bus_busy !== 1'b0) begin
      errors++; $display("FAIL clr_in_xfer: grant=%h err=%b busy=%b want 00 0 0", grant, bus_err, bus_busy);
    end
  endtask

  // model: owner index (-1 = bus free), release flag, transfer start time, completed-transfer count
  task automatic test_random();
    int cur, ptr, done, t, t0, idx, shown;
    bit rel, in_xfer, exp_err;
    logic [7:0] eg;
    do_reset();
    cur = -1; ptr = 0; done = 0; t = 0; t0 = 0; rel = 0; in_xfer = 0; shown = 0;
    for (int c = 0; c < 4000; c++) begin
      clr = ($urandom_range(299) == 0);
      if ($urandom_range(5) == 0) DMA = 8'($urandom & $urandom);
      BUS_req = ($urandom_range(3) == 0);
      BUS_ready = ($urandom_range(11) == 0);
      exp_err = 0;
      t++;
      if (clr) begin
        cur = -1; ptr = 0; done = 0; rel = 0; in_xfer = 0;
      end else if (rel) begin
        ptr = (cur + 1) % N; cur = -1; rel = 0; done = 0;
      end else if (cur < 0) begin
        for (int i = 0; i < N; i++) begin
          idx = (ptr + i) % N;
          if (cur < 0 && ((DMA >> idx) & 8'h01) != 0) cur = idx;
        end
      end else if (in_xfer) begin
        if (BUS_ready) begin in_xfer = 0; done++; end
        else if (t - t0 == TO) begin exp_err = 1; in_xfer = 0; rel = 1; end
      end else if (BUS_req) begin
        in_xfer = 1; t0 = t;
      end else if (((DMA >> cur) & 8'h01) == 0 || (done >= MB && (DMA & ~(8'h01 << cur)) != 0)) begin
        rel = 1;
      end
      cyc();
      eg = (cur >= 0 && !rel) ? 8'h01 << cur : 8'h00;
      checks++;
      if (grant !== eg || bus_busy !== (eg != 0) || bus_err !== exp_err || (eg != 0 && owner !== 3'(cur))) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL rand_c%0d: grant=%h busy=%b err=%b owner=%0d, want %h %b %b %0d", c, grant, bus_busy, bus_err, owner, eg, eg != 0, exp_err, cur);
        end
      end
    end
    clr = 1'b0; DMA = '0; BUS_req = 1'b0; BUS_ready = 1'b0;
  endtask

  initial begin
    clr = 1'b1; DMA = '0; BUS_req = 1'b0; BUS_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_burst_limit();
    test_watchdog();
    test_ready_at_timeout();
    test_mid_transfer();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
